// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared definitions for the VC weighted round-robin arbiter: state
// encoding, default widths and the weight-normalise rule.
package vc_wrr_arbiter_pkg;

  localparam int DEF_WEIGHT_W = 4;
  localparam int DEF_CNT_W    = 8;
  // Widest weight the normalise helper accepts; callers zero-extend into it.
  localparam int MAX_WEIGHT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE0 = 2'd1,
    ST_SERVE1 = 2'd2
  } arb_state_e;

  // A programmed weight of 0 would starve its VC forever, so it means 1.
  function automatic logic [MAX_WEIGHT_W-1:0] norm_weight(input logic [MAX_WEIGHT_W-1:0] w);
    if (w == '0) begin
      return MAX_WEIGHT_W'(1);
    end
    return w;
  endfunction

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// Signal bundle between the VC FIFOs / D-FIFO pause logic / FSM and the
// weighted round-robin arbiter.
//
// Handshake: there is no ready path. pop_vcX is a one-cycle strobe that the
// VC FIFO must honour in the same cycle; it is only raised when the FIFO
// reports non-empty and neither downstream pause is set. pop_delay_vcX is the
// same strobe one cycle later and qualifies the mux data word.
interface vc_wrr_arbiter_if
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int CNT_W    = DEF_CNT_W
) ();

  logic                enable;
  logic                fifo_empty_vc0;
  logic                fifo_empty_vc1;
  logic                fifo_pause_d0;
  logic                fifo_pause_d1;
  logic [WEIGHT_W-1:0] weight_vc0;
  logic [WEIGHT_W-1:0] weight_vc1;
  logic                pop_vc0;
  logic                pop_vc1;
  logic                pop_delay_vc0;
  logic                pop_delay_vc1;
  logic                turn_vc;
  logic [CNT_W-1:0]    grant_cnt_vc0;
  logic [CNT_W-1:0]    grant_cnt_vc1;
  arb_state_e          state_dbg;

  // Side that drives the FIFO status / control and consumes the pops.
  modport master (
    output enable, fifo_empty_vc0, fifo_empty_vc1, fifo_pause_d0, fifo_pause_d1,
    output weight_vc0, weight_vc1,
    input  pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, turn_vc,
    input  grant_cnt_vc0, grant_cnt_vc1, state_dbg
  );

  // The arbiter itself.
  modport slave (
    input  enable, fifo_empty_vc0, fifo_empty_vc1, fifo_pause_d0, fifo_pause_d1,
    input  weight_vc0, weight_vc1,
    output pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, turn_vc,
    output grant_cnt_vc0, grant_cnt_vc1, state_dbg
  );

endinterface

// File: rtl/vc_wrr_arbiter_sat_counter.sv
// Saturating up-counter used for the per-VC grant statistics.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment unless already at all-ones, where the count sticks.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin scheduler draining VC0/VC1 into the shared mux path.
// Each VC gets a turn of up to its weight in pops; an empty turn holder
// yields to the other VC, and any downstream pause stalls both.
module vc_wrr_arbiter
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_L,
  vc_wrr_arbiter_if.slave   bus
);

  arb_state_e          state_q, state_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [WEIGHT_W-1:0] w0_q, w0_d;
  logic [WEIGHT_W-1:0] w1_q, w1_d;
  logic                turn_q, turn_d;
  logic                pop_dly0_q, pop_dly0_d;
  logic                pop_dly1_q, pop_dly1_d;

  logic [WEIGHT_W-1:0] w0_norm;
  logic [WEIGHT_W-1:0] w1_norm;
  logic                stall;
  logic                pop0;
  logic                pop1;

  assign w0_norm = WEIGHT_W'(norm_weight(MAX_WEIGHT_W'(bus.weight_vc0)));
  assign w1_norm = WEIGHT_W'(norm_weight(MAX_WEIGHT_W'(bus.weight_vc1)));
  // The destination D FIFO is unknown until the word is popped, so either
  // pause must block both VCs.
  assign stall   = bus.fifo_pause_d0 | bus.fifo_pause_d1;

  // Next-state, credit and pop selection for the arbiter FSM.
  always_comb begin
    logic                cur;
    logic                empty_cur;
    logic                empty_oth;
    logic                pop_any;
    logic                pop_sel;
    logic [WEIGHT_W-1:0] r;

    state_d   = state_q;
    credit_d  = credit_q;
    w0_d      = w0_q;
    w1_d      = w1_q;
    cur       = (state_q == ST_SERVE1);
    empty_cur = 1'b1;
    empty_oth = 1'b1;
    pop_any   = 1'b0;
    pop_sel   = 1'b0;
    r         = '0;

    case (state_q)
      ST_IDLE: begin
        w0_d = w0_norm;
        w1_d = w1_norm;
        if (bus.enable) begin
          state_d  = ST_SERVE0;
          credit_d = w0_norm;
        end
      end
      default: begin
        if (!bus.enable) begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end else if (!stall) begin
          empty_cur = cur ? bus.fifo_empty_vc1 : bus.fifo_empty_vc0;
          empty_oth = cur ? bus.fifo_empty_vc0 : bus.fifo_empty_vc1;
          if (!empty_cur) begin
            pop_any = 1'b1;
            pop_sel = cur;
          end else if (!empty_oth) begin
            pop_any = 1'b1;
            pop_sel = ~cur;
          end
          if (pop_any) begin
            // A borrowed pop starts a fresh turn for the popping VC.
            r = (pop_sel == cur) ? credit_q : (pop_sel ? w1_q : w0_q);
            if (r <= WEIGHT_W'(1)) begin
              state_d  = pop_sel ? ST_SERVE0 : ST_SERVE1;
              credit_d = pop_sel ? w0_q : w1_q;
            end else begin
              state_d  = pop_sel ? ST_SERVE1 : ST_SERVE0;
              credit_d = r - 1'b1;
            end
          end
        end
      end
    endcase

    pop0       = pop_any & ~pop_sel;
    pop1       = pop_any & pop_sel;
    turn_d     = (state_d == ST_SERVE1);
    pop_dly0_d = pop0;
    pop_dly1_d = pop1;
  end

  // Arbiter FSM state, credit, latched weights and registered outputs.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      w0_q       <= WEIGHT_W'(1);
      w1_q       <= WEIGHT_W'(1);
      turn_q     <= 1'b0;
      pop_dly0_q <= 1'b0;
      pop_dly1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      turn_q     <= turn_d;
      pop_dly0_q <= pop_dly0_d;
      pop_dly1_q <= pop_dly1_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_vc0 (
    .clk     (clk),
    .reset_L (reset_L),
    .inc     (pop0),
    .count   (bus.grant_cnt_vc0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_vc1 (
    .clk     (clk),
    .reset_L (reset_L),
    .inc     (pop1),
    .count   (bus.grant_cnt_vc1)
  );

  assign bus.pop_vc0       = pop0;
  assign bus.pop_vc1       = pop1;
  assign bus.pop_delay_vc0 = pop_dly0_q;
  assign bus.pop_delay_vc1 = pop_dly1_q;
  assign bus.turn_vc       = turn_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed bench for vc_wrr_arbiter: weighted turns, work conservation,
// stall hold, zero weights, async reset and counter saturation.
module tb_vc_wrr_arbiter;
  import vc_wrr_arbiter_pkg::*;

  logic clk;
  logic reset_L;
  int   n_assert;
  int   n_fail;

  vc_wrr_arbiter_if #(.WEIGHT_W(4), .CNT_W(8)) bus ();

  vc_wrr_arbiter #(.WEIGHT_W(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Clock: posedges at 5, 15, 25 ...; negedges at 10, 20 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Move to just after the next falling edge.
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Drop enable for a cycle (SERVE -> IDLE), then re-enable with new weights.
  task automatic restart(input logic [3:0] w0, input logic [3:0] w1);
    bus.enable = 1'b0;
    #1;
    chk("restart_off_pop0", bus.pop_vc0, 1'b0);
    chk("restart_off_pop1", bus.pop_vc1, 1'b0);
    adv();
    bus.weight_vc0 = w0;
    bus.weight_vc1 = w1;
    bus.enable     = 1'b1;
    #1;
    chk("restart_idle_state", bus.state_dbg, ST_IDLE);
    chk("restart_idle_pop",   {bus.pop_vc1, bus.pop_vc0}, 2'b00);
    adv();
  endtask

  initial begin
    logic v;
    logic prev;
    n_assert = 0;
    n_fail   = 0;

    reset_L            = 1'b0;
    bus.enable         = 1'b0;
    bus.fifo_empty_vc0 = 1'b1;
    bus.fifo_empty_vc1 = 1'b1;
    bus.fifo_pause_d0  = 1'b0;
    bus.fifo_pause_d1  = 1'b0;
    bus.weight_vc0     = 4'd1;
    bus.weight_vc1     = 4'd1;

    // Reset state.
    #2;
    chk("rst_pop0",   bus.pop_vc0, 1'b0);
    chk("rst_pop1",   bus.pop_vc1, 1'b0);
    chk("rst_dly0",   bus.pop_delay_vc0, 1'b0);
    chk("rst_dly1",   bus.pop_delay_vc1, 1'b0);
    chk("rst_cnt0",   bus.grant_cnt_vc0, 8'd0);
    chk("rst_cnt1",   bus.grant_cnt_vc1, 8'd0);
    chk("rst_turn",   bus.turn_vc, 1'b0);
    chk("rst_state",  bus.state_dbg, ST_IDLE);
    @(negedge clk);
    #1;
    reset_L = 1'b1;
    adv();

    // 1: weights 3/1, both busy -> 0,0,0,1 repeating.
    bus.weight_vc0     = 4'd3;
    bus.weight_vc1     = 4'd1;
    bus.fifo_empty_vc0 = 1'b0;
    bus.fifo_empty_vc1 = 1'b0;
    bus.enable         = 1'b1;
    #1;
    chk("t1_idle_pop", {bus.pop_vc1, bus.pop_vc0}, 2'b00);
    adv();
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = ((i % 4) == 3);
      #1;
      chk("t1_pop0", bus.pop_vc0, !v);
      chk("t1_pop1", bus.pop_vc1, v);
      chk("t1_turn", bus.turn_vc, v);
      chk("t1_dly0", bus.pop_delay_vc0, (i > 0) && !prev);
      chk("t1_dly1", bus.pop_delay_vc1, (i > 0) && prev);
      prev = v;
      adv();
    end
    chk("t1_cnt0", bus.grant_cnt_vc0, 8'd6);
    chk("t1_cnt1", bus.grant_cnt_vc1, 8'd2);
    chk("t1_dly1_last", bus.pop_delay_vc1, 1'b1);

    // 2: weights 2/2, VC0 empty -> VC1 every cycle, turn toggles.
    bus.fifo_empty_vc0 = 1'b1;
    restart(4'd2, 4'd2);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_pop0", bus.pop_vc0, 1'b0);
      chk("t2_pop1", bus.pop_vc1, 1'b1);
      chk("t2_turn", bus.turn_vc, (i % 2) == 1);
      adv();
    end
    chk("t2_cnt0", bus.grant_cnt_vc0, 8'd6);
    chk("t2_cnt1", bus.grant_cnt_vc1, 8'd8);

    // 3: weights 3/1, pause for 4 cycles after the first VC0 pop.
    bus.fifo_empty_vc0 = 1'b0;
    restart(4'd3, 4'd1);
    #1;
    chk("t3_first_pop0", bus.pop_vc0, 1'b1);
    adv();
    bus.fifo_pause_d1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_stall_pop", {bus.pop_vc1, bus.pop_vc0}, 2'b00);
      chk("t3_stall_turn", bus.turn_vc, 1'b0);
      chk("t3_stall_dly0", bus.pop_delay_vc0, i == 0);
      adv();
    end
    bus.fifo_pause_d1 = 1'b0;
    #1;
    chk("t3_rel_a", {bus.pop_vc1, bus.pop_vc0}, 2'b01);
    adv();
    chk("t3_rel_b", {bus.pop_vc1, bus.pop_vc0}, 2'b01);
    adv();
    chk("t3_rel_c", {bus.pop_vc1, bus.pop_vc0}, 2'b10);
    chk("t3_rel_turn", bus.turn_vc, 1'b1);
    adv();
    chk("t3_cnt0", bus.grant_cnt_vc0, 8'd9);
    chk("t3_cnt1", bus.grant_cnt_vc1, 8'd9);

    // 4: zero weights behave as 1 -> strict alternation.
    restart(4'd0, 4'd0);
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = ((i % 2) == 1);
      #1;
      chk("t4_pop0", bus.pop_vc0, !v);
      chk("t4_pop1", bus.pop_vc1, v);
      chk("t4_dly0", bus.pop_delay_vc0, (i > 0) && !prev);
      chk("t4_dly1", bus.pop_delay_vc1, (i > 0) && prev);
      prev = v;
      adv();
    end
    chk("t4_cnt0", bus.grant_cnt_vc0, 8'd12);
    chk("t4_cnt1", bus.grant_cnt_vc1, 8'd12);

    // 5: async reset while SERVE1 is popping VC1.
    #1;
    chk("t5_pre_pop0", bus.pop_vc0, 1'b1);
    adv();
    #1;
    chk("t5_serve1_pop1", bus.pop_vc1, 1'b1);
    chk("t5_serve1_dly0", bus.pop_delay_vc0, 1'b1);
    #1;
    reset_L = 1'b0;
    #1;
    chk("t5_rst_pop1",  bus.pop_vc1, 1'b0);
    chk("t5_rst_dly0",  bus.pop_delay_vc0, 1'b0);
    chk("t5_rst_dly1",  bus.pop_delay_vc1, 1'b0);
    chk("t5_rst_cnt0",  bus.grant_cnt_vc0, 8'd0);
    chk("t5_rst_cnt1",  bus.grant_cnt_vc1, 8'd0);
    chk("t5_rst_turn",  bus.turn_vc, 1'b0);
    chk("t5_rst_state", bus.state_dbg, ST_IDLE);
    @(negedge clk);
    #1;
    reset_L = 1'b1;
    #1;
    chk("t5_rel_idle_pop", {bus.pop_vc1, bus.pop_vc0}, 2'b00);
    chk("t5_rel_idle_dly", {bus.pop_delay_vc1, bus.pop_delay_vc0}, 2'b00);
    adv();
    chk("t5_first_pop", {bus.pop_vc1, bus.pop_vc0}, 2'b01);

    // 6: VC0 alone for 300 cycles -> counter saturates, then disable.
    bus.fifo_empty_vc1 = 1'b1;
    adv();
    chk("t5_cnt0_one", bus.grant_cnt_vc0, 8'd1);
    for (int i = 0; i < 300; i++) begin
      chk("t6_pop0", bus.pop_vc0, 1'b1);
      adv();
    end
    chk("t6_cnt0_sat", bus.grant_cnt_vc0, 8'd255);
    chk("t6_cnt1", bus.grant_cnt_vc1, 8'd0);
    bus.enable = 1'b0;
    #1;
    chk("t6_off_pop0", bus.pop_vc0, 1'b0);
    adv();
    chk("t6_idle_state", bus.state_dbg, ST_IDLE);
    chk("t6_idle_pop0",  bus.pop_vc0, 1'b0);
    chk("t6_idle_dly0",  bus.pop_delay_vc0, 1'b0);
    chk("t6_idle_cnt0",  bus.grant_cnt_vc0, 8'd255);
    chk("t6_idle_turn",  bus.turn_vc, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
